// File: rtl/vext_unit.sv
// Operand-extension unit: vsext/vzext.vf2/vf4/vf8 expansion and simm5/scalar broadcast.
// Accepts one request per idle slot (or on last-beat consumption) and emits 1..8 registered beats.
module vext_unit #(
    parameter int unsigned DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic              in_signed,
    input  logic [1:0]        in_frac,
    input  logic [1:0]        in_sew,
    input  logic [DATA_W-1:0] in_data,
    input  logic [4:0]        in_simm5,
    input  logic [31:0]       in_scalar,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              out_err
);

    localparam int unsigned NMAX = DATA_W / 8;

    typedef enum logic {IDLE, EMIT} state_t;

    state_t            state_q, state_d;
    logic [2:0]        beat_q, beat_d;
    logic [2:0]        last_idx_q, last_idx_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              sgn_q, sgn_d;
    logic [1:0]        frac_q, frac_d;
    logic [1:0]        sew_q, sew_d;
    logic              out_valid_d, out_last_d, out_err_d;
    logic [DATA_W-1:0] out_data_d;

    logic              handshake;
    logic              accept;
    logic              illegal;
    logic [2:0]        req_last_idx;
    logic [63:0]       scalar_ext;

    // Low-order mask of the given width; width 64 (or more) yields all ones.
    function automatic logic [63:0] lane_mask(input int unsigned width);
        return (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    endfunction

    // Replicate the low SEW bits of v across every element of the lane.
    function automatic logic [DATA_W-1:0] replicate(input logic [63:0] v, input logic [1:0] sew);
        logic [DATA_W-1:0] r;
        int unsigned       sew_b;
        r     = '0;
        sew_b = 32'd8 << sew;
        for (int unsigned i = 0; i < NMAX; i++) begin
            if (i * sew_b < DATA_W) begin
                r = r | (DATA_W'(v & lane_mask(sew_b)) << (i * sew_b));
            end
        end
        return r;
    endfunction

    // Build beat k of an extension: element i takes source element k*N+i, widened to SEW.
    function automatic logic [DATA_W-1:0] ext_beat(
        input logic [DATA_W-1:0] src,
        input logic              sgn,
        input logic [1:0]        sew,
        input logic [1:0]        frac,
        input logic [2:0]        k
    );
        logic [DATA_W-1:0] r;
        logic [DATA_W-1:0] sh;
        logic [63:0]       e;
        logic [63:0]       m;
        logic [63:0]       top;
        int unsigned       sew_b;
        int unsigned       s_b;
        int unsigned       n;
        r     = '0;
        sew_b = 32'd8 << sew;
        s_b   = sew_b >> frac;
        n     = DATA_W / sew_b;
        m     = lane_mask(s_b);
        top   = m & ~(m >> 1);
        for (int unsigned i = 0; i < NMAX; i++) begin
            if (i < n) begin
                sh = src >> (((32'(k) * n) + i) * s_b);
                e  = sh[63:0] & m;
                if (sgn && (|(e & top))) begin
                    e = e | ~m;
                end
                r = r | (DATA_W'(e & lane_mask(sew_b)) << (i * sew_b));
            end
        end
        return r;
    endfunction

    // Request decode: legality and index of the final beat.
    always_comb begin
        illegal      = (in_op == 2'b11) ||
                       ((in_op == 2'b00) && ((in_frac == 2'b00) || (in_frac > in_sew)));
        req_last_idx = 3'd0;
        if ((in_op == 2'b00) && !illegal) begin
            req_last_idx = 3'((4'd1 << in_frac) - 4'd1);
        end
        scalar_ext = (in_sew == 2'b11) ? {{32{in_scalar[31]}}, in_scalar} : {32'd0, in_scalar};
    end

    // Next-state, handshake and next-output logic.
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        last_idx_d  = last_idx_q;
        data_d      = data_q;
        sgn_d       = sgn_q;
        frac_d      = frac_q;
        sew_d       = sew_q;
        out_valid_d = out_valid;
        out_data_d  = out_data;
        out_last_d  = out_last;
        out_err_d   = out_err;

        handshake = out_valid && out_ready;
        in_ready  = (state_q == IDLE) || (handshake && out_last);
        accept    = in_valid && in_ready;

        if (accept) begin
            state_d     = EMIT;
            beat_d      = 3'd0;
            last_idx_d  = req_last_idx;
            data_d      = in_data;
            sgn_d       = in_signed;
            frac_d      = in_frac;
            sew_d       = in_sew;
            out_valid_d = 1'b1;
            out_last_d  = (req_last_idx == 3'd0);
            out_err_d   = illegal;
            if (illegal) begin
                out_data_d = '0;
            end else begin
                case (in_op)
                    2'b00:   out_data_d = ext_beat(in_data, in_signed, in_sew, in_frac, 3'd0);
                    2'b01:   out_data_d = replicate({{59{in_simm5[4]}}, in_simm5}, in_sew);
                    default: out_data_d = replicate(scalar_ext, in_sew);
                endcase
            end
        end else if ((state_q == EMIT) && handshake) begin
            if (out_last) begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
                out_err_d   = 1'b0;
            end else begin
                beat_d     = beat_q + 3'd1;
                out_data_d = ext_beat(data_q, sgn_q, sew_q, frac_q, beat_q + 3'd1);
                out_last_d = ((beat_q + 3'd1) == last_idx_q);
            end
        end
    end

    // State, captured request and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            beat_q     <= 3'd0;
            last_idx_q <= 3'd0;
            data_q     <= '0;
            sgn_q      <= 1'b0;
            frac_q     <= 2'b00;
            sew_q      <= 2'b00;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
            out_err    <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            last_idx_q <= last_idx_d;
            data_q     <= data_d;
            sgn_q      <= sgn_d;
            frac_q     <= frac_d;
            sew_q      <= sew_d;
            out_valid  <= out_valid_d;
            out_data   <= out_data_d;
            out_last   <= out_last_d;
            out_err    <= out_err_d;
        end
    end

endmodule

// File: tb/tb_vext_unit.sv
// Testbench for vext_unit: directed table, back-to-back/stall/reset sequences, random requests.
module tb_vext_unit;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic        in_signed;
    logic [1:0]  in_frac;
    logic [1:0]  in_sew;
    logic [63:0] in_data;
    logic [4:0]  in_simm5;
    logic [31:0] in_scalar;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        out_last;
    logic        out_err;

    vext_unit #(.DATA_W(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_signed (in_signed),
        .in_frac   (in_frac),
        .in_sew    (in_sew),
        .in_data   (in_data),
        .in_simm5  (in_simm5),
        .in_scalar (in_scalar),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_err   (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic        sgn;
        logic [1:0]  frac;
        logic [1:0]  sew;
        logic [63:0] data;
        logic [4:0]  simm5;
        logic [31:0] scalar;
        logic [63:0] exp0;
        int          exp_n;
        logic        exp_err;
    } vec_t;

    vec_t        tbl[13];
    int          n_chk;
    int          n_fail;
    logic [63:0] exp_beats[8];
    int          exp_n;
    logic        exp_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic longint unsigned lmask(input int unsigned b);
        return (b >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << b) - 64'd1);
    endfunction

    // Reference: list source elements, widen each arithmetically, pack N per beat.
    function automatic void model(input vec_t r);
        int unsigned       sew_b;
        int unsigned       s_b;
        int unsigned       f;
        int unsigned       n;
        longint unsigned   e;
        longint unsigned   v;
        sew_b = 8 << r.sew;
        n     = 64 / sew_b;
        for (int k = 0; k < 8; k++) exp_beats[k] = 64'd0;
        exp_err = (r.op == 2'd3) ||
                  ((r.op == 2'd0) && ((r.frac == 2'd0) || ((sew_b / (1 << r.frac)) < 8)));
        exp_n = 1;
        if (exp_err) begin
            exp_beats[0] = 64'd0;
        end else if (r.op == 2'd0) begin
            f     = 1 << r.frac;
            s_b   = sew_b / f;
            exp_n = int'(f);
            for (int unsigned k = 0; k < f; k++) begin
                for (int unsigned i = 0; i < n; i++) begin
                    e = (r.data >> ((k * n + i) * s_b)) % (64'd1 << s_b);
                    if (r.sgn && (e >= (64'd1 << (s_b - 1)))) e = e - (64'd1 << s_b);
                    exp_beats[k] = exp_beats[k] | ((e & lmask(sew_b)) << (i * sew_b));
                end
            end
        end else begin
            if (r.op == 2'd1) begin
                v = 64'(r.simm5);
                if (r.simm5 >= 5'd16) v = v - 64'd32;
            end else begin
                v = 64'(r.scalar);
                if ((sew_b == 64) && (r.scalar >= 32'h8000_0000)) v = v - 64'h1_0000_0000;
            end
            for (int unsigned i = 0; i < n; i++) begin
                exp_beats[0] = exp_beats[0] | ((v & lmask(sew_b)) << (i * sew_b));
            end
        end
    endfunction

    task automatic drive(input vec_t r);
        in_op     = r.op;
        in_signed = r.sgn;
        in_frac   = r.frac;
        in_sew    = r.sew;
        in_data   = r.data;
        in_simm5  = r.simm5;
        in_scalar = r.scalar;
    endtask

    task automatic scramble();
        in_data   = {$urandom, $urandom};
        in_simm5  = 5'($urandom);
        in_scalar = $urandom;
        in_signed = 1'($urandom);
        in_frac   = 2'($urandom);
        in_sew    = 2'($urandom);
    endtask

    // One full request: accept, then every beat checked, optional random stalls.
    task automatic run_req(input vec_t r, input int stall_pct, input bit use_tbl);
        int cnt;
        model(r);
        @(negedge clk);
        drive(r);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        cnt = 0;
        while (!in_ready && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 64'(in_ready), 64'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        scramble();
        for (int k = 0; k < exp_n; k++) begin
            @(negedge clk);
            if (int'($urandom_range(99)) < stall_pct) begin
                out_ready = 1'b0;
                repeat ($urandom_range(3, 1)) begin
                    @(negedge clk);
                    chk("stall_data", out_data, exp_beats[k]);
                    chk("stall_in_ready", 64'(in_ready), 64'd0);
                end
                out_ready = 1'b1;
            end
            chk("beat_valid", 64'(out_valid), 64'd1);
            chk("beat_data", out_data, exp_beats[k]);
            chk("beat_last", 64'(out_last), 64'(k == exp_n - 1));
            chk("beat_err", 64'(out_err), 64'(exp_err));
            if (use_tbl && k == 0) begin
                chk("tbl_beat0", out_data, r.exp0);
                chk("tbl_err", 64'(out_err), 64'(r.exp_err));
                chk("tbl_count", 64'(exp_n), 64'(r.exp_n));
            end
        end
        @(negedge clk);
        chk("idle_after", 64'(out_valid), 64'd0);
    endtask

    initial begin
        vec_t        a;
        vec_t        b;
        vec_t        rv;
        logic [63:0] a_beats[8];

        n_chk  = 0;
        n_fail = 0;
        tbl[0]  = '{2'b00, 1'b1, 2'b01, 2'b01, 64'h0000_0000_80FF_7F01, 5'd0, 32'd0, 64'hFF80_FFFF_007F_0001, 2, 1'b0};
        tbl[1]  = '{2'b00, 1'b0, 2'b11, 2'b11, 64'h8081_8283_8485_8687, 5'd0, 32'd0, 64'h0000_0000_0000_0087, 8, 1'b0};
        tbl[2]  = '{2'b00, 1'b1, 2'b11, 2'b11, 64'h8081_8283_8485_8687, 5'd0, 32'd0, 64'hFFFF_FFFF_FFFF_FF87, 8, 1'b0};
        tbl[3]  = '{2'b01, 1'b0, 2'b00, 2'b10, 64'd0, 5'b10000, 32'd0, 64'hFFFF_FFF0_FFFF_FFF0, 1, 1'b0};
        tbl[4]  = '{2'b10, 1'b0, 2'b00, 2'b11, 64'd0, 5'd0, 32'h8000_0001, 64'hFFFF_FFFF_8000_0001, 1, 1'b0};
        tbl[5]  = '{2'b10, 1'b0, 2'b00, 2'b01, 64'd0, 5'd0, 32'h8000_0001, 64'h0001_0001_0001_0001, 1, 1'b0};
        tbl[6]  = '{2'b00, 1'b1, 2'b11, 2'b01, 64'hDEAD_BEEF_1234_5678, 5'd0, 32'd0, 64'd0, 1, 1'b1};
        tbl[7]  = '{2'b11, 1'b0, 2'b01, 2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 5'd7, 32'd9, 64'd0, 1, 1'b1};
        tbl[8]  = '{2'b00, 1'b0, 2'b00, 2'b11, 64'h1111_2222_3333_4444, 5'd0, 32'd0, 64'd0, 1, 1'b1};
        tbl[9]  = '{2'b00, 1'b1, 2'b01, 2'b00, 64'h1111_2222_3333_4444, 5'd0, 32'd0, 64'd0, 1, 1'b1};
        tbl[10] = '{2'b00, 1'b0, 2'b01, 2'b11, 64'h8000_0000_FFFF_FFFF, 5'd0, 32'd0, 64'h0000_0000_FFFF_FFFF, 2, 1'b0};
        tbl[11] = '{2'b01, 1'b1, 2'b00, 2'b00, 64'd0, 5'b01111, 32'd0, 64'h0F0F_0F0F_0F0F_0F0F, 1, 1'b0};
        tbl[12] = '{2'b00, 1'b1, 2'b10, 2'b10, 64'h0000_0000_0000_817F, 5'd0, 32'd0, 64'hFFFF_FF81_0000_007F, 4, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        drive(tbl[0]);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_out_err", 64'(out_err), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        for (int t = 0; t < 13; t++) run_req(tbl[t], 0, 1'b1);

        // vf4 with a 3-cycle stall on beat 1, then a request accepted at last-beat consumption.
        a = '{2'b00, 1'b0, 2'b10, 2'b10, 64'h0000_0000_A1B2_C3D4, 5'd0, 32'd0, 64'd0, 4, 1'b0};
        b = tbl[3];
        model(a);
        for (int k = 0; k < 8; k++) a_beats[k] = exp_beats[k];
        model(b);
        @(negedge clk);
        drive(a);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        chk("b2b_idle_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        scramble();
        @(negedge clk);
        chk("b2b_beat0", out_data, a_beats[0]);
        @(negedge clk);
        chk("b2b_beat1", out_data, a_beats[1]);
        out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("b2b_hold_data", out_data, a_beats[1]);
            chk("b2b_hold_last", 64'(out_last), 64'd0);
            chk("b2b_hold_valid", 64'(out_valid), 64'd1);
            chk("b2b_hold_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("b2b_beat2", out_data, a_beats[2]);
        @(negedge clk);
        chk("b2b_beat3", out_data, a_beats[3]);
        chk("b2b_last3", 64'(out_last), 64'd1);
        drive(b);
        in_valid = 1'b1;
        chk("b2b_accept_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_next_valid", 64'(out_valid), 64'd1);
        chk("b2b_next_data", out_data, exp_beats[0]);
        chk("b2b_next_last", 64'(out_last), 64'd1);
        @(negedge clk);
        chk("b2b_idle", 64'(out_valid), 64'd0);

        // Reset while beat 2 of a vf4 request is on the bus.
        model(a);
        @(negedge clk);
        drive(a);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("rstmid_beat2", out_data, exp_beats[2]);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_valid", 64'(out_valid), 64'd0);
        chk("rstmid_in_ready", 64'(in_ready), 64'd1);
        chk("rstmid_data", out_data, 64'd0);
        chk("rstmid_last", 64'(out_last), 64'd0);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("rstmid_no_beats", 64'(out_valid), 64'd0);
        end

        // Random requests with random consumer stalls.
        for (int t = 0; t < 150; t++) begin
            rv.op     = 2'($urandom);
            rv.sgn    = 1'($urandom);
            rv.frac   = 2'($urandom);
            rv.sew    = 2'($urandom);
            rv.data   = {$urandom, $urandom};
            rv.simm5  = 5'($urandom);
            rv.scalar = $urandom;
            rv.exp0   = 64'd0;
            rv.exp_n  = 0;
            rv.exp_err = 1'b0;
            run_req(rv, 30, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/vext_unit.md
# vext_unit

Pipelined, parametrised operand-extension unit for the vector datapath. It implements vsext/vzext.vf2/vf4/vf8, where one packed source word expands into 2/4/8 output beats. It also generates broadcast operands: simm5 or a 32-bit scalar, sign-extended to SEW and replicated across the lane. It sits between the vector register-file read port and the vector ALU operand bus, with valid/ready on both sides.

## Interface
- DATA_W, 64: lane width in bits; multiple of 64.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request this cycle.
- in_op  in  2  00 = EXT, 01 = BCAST_IMM, 10 = BCAST_SCALAR, 11 = reserved (illegal).
- in_signed  in  1  EXT only: 1 = sign-extend, 0 = zero-extend.
- in_frac  in  2  EXT only: 01 = vf2, 10 = vf4, 11 = vf8, 00 = illegal.
- in_sew  in  2  destination SEW: 00 = 8, 01 = 16, 10 = 32, 11 = 64.
- in_data  in  DATA_W  packed source elements (EXT).
- in_simm5  in  5  immediate (BCAST_IMM).
- in_scalar  in  32  scalar operand (BCAST_SCALAR).
- out_valid  out  1  output beat valid.
- out_ready  in  1  consumer accepts beat.
- out_data  out  DATA_W  extended/broadcast elements.
- out_last  out  1  final beat of current request.
- out_err  out  1  request was illegal; beat carries zeros.

## Operation
- FSM states are IDLE and EMIT, with a beat counter (3 bits) and a registered copy of the request fields.
- in_ready = (state == IDLE) or (state == EMIT and out_valid and out_ready and out_last).
- A request is accepted when in_valid and in_ready.
- Beat count per op:
  - EXT: F = 2/4/8 beats.
  - BCAST ops: 1 beat.
  - Illegal request: 1 beat.
- EXT element mapping:
  - Source width S = SEW/F; elements per beat N = DATA_W/SEW.
  - Beat k, element i takes source bits in_data[(k*N+i)*S +: S], extended to SEW and placed at out_data[i*SEW +: SEW].
  - Element 0 is at the LSBs.
- BCAST_IMM: simm5 is sign-extended to SEW and replicated N times.
- BCAST_SCALAR:
  - SEW = 64: scalar is sign-extended 32→64.
  - SEW < 64: the low SEW bits of the scalar are used.
  - The value is replicated N times.
- Illegal requests:
  - in_op = 11.
  - EXT with in_frac = 00.
  - EXT with S < 8: SEW 8 with any frac; SEW 16 with vf4/vf8; SEW 32 with vf8.
  - Response: one beat, out_data = 0, out_err = 1, out_last = 1.
- out_err is 0 on every legal beat.
- Transitions:
  - IDLE→EMIT on accept.
  - EMIT: beat advances on out_valid and out_ready.
  - EMIT→IDLE when the last beat is consumed with no new accept.
  - EMIT→EMIT (beat = 0, new request loaded) when the last beat is consumed with a simultaneous accept.
- in_data is captured at accept; later input changes do not affect the remaining beats.

## Timing
- Reset values:
  - state = IDLE, beat = 0.
  - out_valid = 0, out_data = 0, out_last = 0, out_err = 0.
  - in_ready = 1 in the cycle after rst deasserts.
- Latency: the first beat is valid in the cycle after accept, with registered outputs.
- Throughput: one beat per cycle under continuous out_ready. Back-to-back requests have no bubble, because the last beat and the next accept occur in the same cycle.
- Stall: while out_valid and !out_ready, out_data, out_last and out_err hold stable, and in_ready = 0.
- out_valid never drops without a handshake.
- out_last is asserted only on beat F-1 (or on the single beat).
- rst mid-request aborts it: the next cycle shows IDLE reset values, and the remaining beats are never emitted.
- rst has priority over any simultaneous accept or handshake.

## Test plan
- vf2 sign, SEW = 16, in_data = 0x0000_0000_80FF_7F01 -> beat0 0xFF80_FFFF_007F_0001, last = 0; beat1 0x0000_0000_0000_0000, last = 1.
- vf8 with in_data = 0x8081_8283_8485_8687, SEW = 64:
  - zero-extend -> 8 beats 0x87, 0x86, …, 0x80, last only on beat 8.
  - sign-extend -> beat0 0xFFFF_FFFF_FFFF_FF87.
- BCAST_IMM, SEW = 32, simm5 = 10000b -> one beat 0xFFFF_FFF0_FFFF_FFF0, last = 1.
- BCAST_SCALAR, scalar = 0x8000_0001:
  - SEW = 64 -> 0xFFFF_FFFF_8000_0001.
  - SEW = 16 -> 0x0001_0001_0001_0001.
- vf4 with out_ready held low for 3 cycles on beat 1 -> out_data and out_last held, in_ready = 0. A second request presented at last-beat consumption is accepted in that same cycle; its beat0 appears the next cycle with no gap.
- Illegal EXT SEW = 16 vf8 -> one beat, out_data = 0, out_err = 1, out_last = 1.
- rst asserted during beat 2 of vf4 -> next cycle out_valid = 0, in_ready = 1, and no further beats.
